// File: rtl/mem_arb_pkg.sv
// Shared types for the unified instruction/data memory arbiter.
// Owner and state encodings are used by the top level and the grant picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant picker: data has priority, but a run of DSTREAK_MAX data grants
// while fetch is waiting hands the next window to fetch.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic d_req,
  input  logic window,
  output logic if_gnt,
  output logic d_gnt
);

  localparam logic [STREAK_W-1:0] STREAK_LIM  = STREAK_W'(DSTREAK_MAX);
  localparam logic [STREAK_W-1:0] STREAK_ZERO = {STREAK_W{1'b0}};
  localparam logic [STREAK_W-1:0] STREAK_ONE  = {{(STREAK_W-1){1'b0}}, 1'b1};

  logic [STREAK_W-1:0] dstreak_q;
  logic [STREAK_W-1:0] dstreak_d;
  logic                limit_hit_s;

  assign limit_hit_s = (dstreak_q == STREAK_LIM);

  // One-hot grant decision, only inside the arbitration window.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (window) begin
      if (d_req && !limit_hit_s) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end else begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
      end
    end else begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
    end
  end

  // Streak only grows while fetch is actually waiting on data grants.
  always_comb begin
    dstreak_d = dstreak_q;
    if (!if_req) begin
      dstreak_d = STREAK_ZERO;
    end else if (if_gnt) begin
      dstreak_d = STREAK_ZERO;
    end else if (d_gnt) begin
      dstreak_d = dstreak_q + STREAK_ONE;
    end else begin
      dstreak_d = dstreak_q;
    end
  end

  // Streak register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dstreak_q <= STREAK_ZERO;
    end else begin
      dstreak_q <= dstreak_d;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one access in flight, with a grant window on the last cycle of each access.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 2,
  parameter int DSTREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic [31:0]   fetch_stall_cnt
);

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);
  localparam logic [3:0] LAT_ONE  = 4'd1;

  arb_state_t  state_q;
  arb_state_t  state_d;
  logic [3:0]  lat_cnt_q;
  logic [3:0]  lat_cnt_d;
  owner_t      owner_q;
  owner_t      owner_d;
  logic        store_q;
  logic        store_d;
  logic [31:0] fetch_stall_cnt_q;
  logic [31:0] fetch_stall_cnt_d;

  logic        last_s;
  logic        window_s;
  logic        gnt_s;

  // Reset gates the window so grants and mem_* stay low while held in reset.
  assign last_s   = (state_q == BUSY) && (lat_cnt_q == LAT_ONE);
  assign window_s = reset && ((state_q == IDLE) || last_s);
  assign gnt_s    = if_gnt || d_gnt;

  mem_arb_pick #(
    .DSTREAK_MAX(DSTREAK_MAX)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .if_req (if_req),
    .d_req  (d_req),
    .window (window_s),
    .if_gnt (if_gnt),
    .d_gnt  (d_gnt)
  );

  // Next-state logic for the access FSM and its latency counter.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    store_d   = store_q;
    case (state_q)
      IDLE: begin
        if (gnt_s) begin
          state_d   = BUSY;
          lat_cnt_d = LAT_INIT;
          owner_d   = if_gnt ? OWN_IF : OWN_D;
          store_d   = d_gnt && d_we;
        end else begin
          state_d   = IDLE;
        end
      end
      BUSY: begin
        if (gnt_s) begin
          state_d   = BUSY;
          lat_cnt_d = LAT_INIT;
          owner_d   = if_gnt ? OWN_IF : OWN_D;
          store_d   = d_gnt && d_we;
        end else if (last_s) begin
          state_d   = IDLE;
          lat_cnt_d = 4'd0;
          owner_d   = OWN_NONE;
          store_d   = 1'b0;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        lat_cnt_d = 4'd0;
        owner_d   = OWN_NONE;
        store_d   = 1'b0;
      end
    endcase
  end

  // Memory strobe carries the granted requester's fields in the grant cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Response routing: rvalid reflects the owner that issued the access.
  always_comb begin
    if_rvalid = reset && last_s && (owner_q == OWN_IF);
    d_rvalid  = reset && last_s && (owner_q == OWN_D);
    if_rdata  = {DW{1'b0}};
    d_rdata   = {DW{1'b0}};
    if (if_rvalid) begin
      if_rdata = mem_rdata;
    end else if (d_rvalid && !store_q) begin
      d_rdata = mem_rdata;
    end else begin
      if_rdata = {DW{1'b0}};
      d_rdata  = {DW{1'b0}};
    end
  end

  // Saturating count of cycles fetch spends waiting for a grant.
  always_comb begin
    fetch_stall_cnt_d = fetch_stall_cnt_q;
    if (if_req && !if_gnt && (fetch_stall_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_stall_cnt_d = fetch_stall_cnt_q + 32'd1;
    end else begin
      fetch_stall_cnt_d = fetch_stall_cnt_q;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= IDLE;
      lat_cnt_q         <= 4'd0;
      owner_q           <= OWN_NONE;
      store_q           <= 1'b0;
      fetch_stall_cnt_q <= 32'd0;
    end else begin
      state_q           <= state_d;
      lat_cnt_q         <= lat_cnt_d;
      owner_q           <= owner_d;
      store_q           <= store_d;
      fetch_stall_cnt_q <= fetch_stall_cnt_d;
    end
  end

  assign busy            = (state_q == BUSY);
  assign fetch_stall_cnt = fetch_stall_cnt_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (MEM_LAT 2, 3, 1), each with a
// memory model and a cycle-numbered reference model checked every cycle.
module tb_unified_mem_arbiter;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst       [NI];
  logic        if_req    [NI];
  logic [31:0] if_addr   [NI];
  logic        if_gnt    [NI];
  logic        if_rvalid [NI];
  logic [31:0] if_rdata  [NI];
  logic        d_req     [NI];
  logic        d_we      [NI];
  logic [31:0] d_addr    [NI];
  logic [31:0] d_wdata   [NI];
  logic        d_gnt     [NI];
  logic        d_rvalid  [NI];
  logic [31:0] d_rdata   [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic        busy      [NI];
  logic [31:0] stall     [NI];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk1(input string nm, input int k, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %b expected %b", nm, k, $time, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 3 : 1);

    unified_mem_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(L), .DSTREAK_MAX(4)
    ) u_dut (
      .clk             (clk),
      .reset           (rst[g]),
      .if_req          (if_req[g]),
      .if_addr         (if_addr[g]),
      .if_gnt          (if_gnt[g]),
      .if_rvalid       (if_rvalid[g]),
      .if_rdata        (if_rdata[g]),
      .d_req           (d_req[g]),
      .d_we            (d_we[g]),
      .d_addr          (d_addr[g]),
      .d_wdata         (d_wdata[g]),
      .d_gnt           (d_gnt[g]),
      .d_rvalid        (d_rvalid[g]),
      .d_rdata         (d_rdata[g]),
      .mem_en          (mem_en[g]),
      .mem_we          (mem_we[g]),
      .mem_addr        (mem_addr[g]),
      .mem_wdata       (mem_wdata[g]),
      .mem_rdata       (mem_rdata[g]),
      .busy            (busy[g]),
      .fetch_stall_cnt (stall[g])
    );

    // Memory model: access happens at the issue edge, data appears L cycles later.
    logic [31:0] mem   [64];
    bit          mwr   [64];
    logic [31:0] pipe  [16];
    logic        cap_en;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    assign mem_rdata[g] = pipe[L-1];

    always @(negedge clk) begin
      cap_en    <= mem_en[g];
      cap_we    <= mem_we[g];
      cap_addr  <= mem_addr[g];
      cap_wdata <= mem_wdata[g];
    end

    always @(posedge clk) begin
      for (int i = 15; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= 32'h0;
      if (cap_en) begin
        if (cap_we) begin
          mem[cap_addr[7:2]] <= cap_wdata;
          mwr[cap_addr[7:2]] <= 1'b1;
        end else begin
          pipe[0] <= mwr[cap_addr[7:2]] ? mem[cap_addr[7:2]] : init_word(int'(cap_addr[7:2]));
        end
      end
    end

    // Reference model in absolute cycle numbers: one pending access, done at issue+L.
    int          cyc = 0;
    bit          pv = 1'b0;
    int          p_issue = 0;
    int          p_done = 0;
    bit          p_isd = 1'b0;
    logic [31:0] p_data = 32'h0;
    int          streak = 0;
    logic [31:0] stall_m = 32'h0;
    logic [31:0] gold [64];
    bit          gwr  [64];

    always @(negedge clk) begin : model
      logic        e_if, e_d, e_rv, win;
      logic [5:0]  idx;
      logic [31:0] rd;
      if (!rst[g]) begin
        chk1("m_if_gnt", g, if_gnt[g], 1'b0);
        chk1("m_d_gnt", g, d_gnt[g], 1'b0);
        chk1("m_if_rvalid", g, if_rvalid[g], 1'b0);
        chk1("m_d_rvalid", g, d_rvalid[g], 1'b0);
        chk32("m_if_rdata", g, if_rdata[g], 32'h0);
        chk32("m_d_rdata", g, d_rdata[g], 32'h0);
        chk1("m_mem_en", g, mem_en[g], 1'b0);
        chk1("m_mem_we", g, mem_we[g], 1'b0);
        chk32("m_mem_addr", g, mem_addr[g], 32'h0);
        chk32("m_mem_wdata", g, mem_wdata[g], 32'h0);
        chk1("m_busy", g, busy[g], 1'b0);
        chk32("m_stall", g, stall[g], 32'h0);
        pv      <= 1'b0;
        streak  <= 0;
        stall_m <= 32'h0;
        cyc     <= 0;
      end else begin
        win  = !pv || (cyc >= p_done);
        e_if = 1'b0;
        e_d  = 1'b0;
        if (win) begin
          if (d_req[g] && streak < 4) e_d = 1'b1;
          else if (if_req[g]) e_if = 1'b1;
          else if (d_req[g]) e_d = 1'b1;
        end
        e_rv = pv && (cyc == p_done);
        chk1("m_if_gnt", g, if_gnt[g], e_if);
        chk1("m_d_gnt", g, d_gnt[g], e_d);
        chk1("m_if_rvalid", g, if_rvalid[g], e_rv && !p_isd);
        chk1("m_d_rvalid", g, d_rvalid[g], e_rv && p_isd);
        chk32("m_if_rdata", g, if_rdata[g], (e_rv && !p_isd) ? p_data : 32'h0);
        chk32("m_d_rdata", g, d_rdata[g], (e_rv && p_isd) ? p_data : 32'h0);
        chk1("m_mem_en", g, mem_en[g], e_if || e_d);
        chk1("m_mem_we", g, mem_we[g], e_d && d_we[g]);
        chk32("m_mem_addr", g, mem_addr[g], e_if ? if_addr[g] : (e_d ? d_addr[g] : 32'h0));
        chk32("m_mem_wdata", g, mem_wdata[g], e_d ? d_wdata[g] : 32'h0);
        chk1("m_busy", g, busy[g], pv && (cyc > p_issue));
        chk32("m_stall", g, stall[g], stall_m);

        if (e_rv) pv <= 1'b0;
        if (e_if || e_d) begin
          idx = e_d ? d_addr[g][7:2] : if_addr[g][7:2];
          rd  = gwr[idx] ? gold[idx] : init_word(int'(idx));
          pv      <= 1'b1;
          p_issue <= cyc;
          p_done  <= cyc + L;
          p_isd   <= e_d;
          if (e_d && d_we[g]) begin
            p_data    <= 32'h0;
            gold[idx] <= d_wdata[g];
            gwr[idx]  <= 1'b1;
          end else begin
            p_data <= rd;
          end
        end
        if (!if_req[g] || e_if) streak <= 0;
        else if (e_d) streak <= streak + 1;
        if (if_req[g] && !e_if && stall_m != 32'hFFFF_FFFF) stall_m <= stall_m + 32'd1;
        cyc <= cyc + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] seq;
    int          ng;
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = 32'h0; d_req[k] = 1'b0;
      d_we[k] = 1'b0; d_addr[k] = 32'h0; d_wdata[k] = 32'h0;
    end
    // Requests during reset must not produce grants or memory strobes.
    if_req[0] = 1'b1; if_addr[0] = 32'h8; d_req[1] = 1'b1; d_addr[1] = 32'h20;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk1("rst_if_gnt", k, if_gnt[k], 1'b0);
      chk1("rst_d_gnt", k, d_gnt[k], 1'b0);
      chk1("rst_mem_en", k, mem_en[k], 1'b0);
      chk1("rst_busy", k, busy[k], 1'b0);
      chk32("rst_stall", k, stall[k], 32'h0);
    end
    tick();
    if_req[0] = 1'b0; d_req[1] = 1'b0;
    for (int k = 0; k < NI; k++) rst[k] = 1'b1;

    // Single fetch, MEM_LAT = 2.
    tick();
    if_req[0] = 1'b1; if_addr[0] = 32'h8;
    @(negedge clk);
    chk1("fetch_gnt", 0, if_gnt[0], 1'b1);
    chk32("fetch_mem_addr", 0, mem_addr[0], 32'h8);
    chk1("fetch_busy_c0", 0, busy[0], 1'b0);
    tick();
    if_req[0] = 1'b0;
    @(negedge clk);
    chk1("fetch_busy_c1", 0, busy[0], 1'b1);
    chk1("fetch_rvalid_c1", 0, if_rvalid[0], 1'b0);
    tick();
    @(negedge clk);
    chk1("fetch_rvalid_c2", 0, if_rvalid[0], 1'b1);
    chk32("fetch_rdata", 0, if_rdata[0], 32'hC0DE_0002);
    chk1("fetch_busy_c2", 0, busy[0], 1'b1);
    tick();
    @(negedge clk);
    chk1("fetch_busy_c3", 0, busy[0], 1'b0);

    // Collision: data first, fetch granted in the load's rvalid cycle.
    tick();
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h60;
    @(negedge clk);
    chk1("col_d_gnt", 0, d_gnt[0], 1'b1);
    chk1("col_if_gnt_c0", 0, if_gnt[0], 1'b0);
    chk32("col_mem_addr", 0, mem_addr[0], 32'h60);
    tick();
    d_req[0] = 1'b0;
    @(negedge clk);
    chk1("col_if_gnt_c1", 0, if_gnt[0], 1'b0);
    tick();
    @(negedge clk);
    chk1("col_d_rvalid", 0, d_rvalid[0], 1'b1);
    chk32("col_d_rdata", 0, d_rdata[0], 32'hC0DE_0018);
    chk1("col_if_gnt_c2", 0, if_gnt[0], 1'b1);
    chk32("col_stall", 0, stall[0], 32'd2);
    tick();
    if_req[0] = 1'b0;
    tick();
    @(negedge clk);
    chk1("col_if_rvalid", 0, if_rvalid[0], 1'b1);
    chk32("col_if_rdata", 0, if_rdata[0], 32'hC0DE_0004);

    // Store 25 to 0x64, then load it back.
    tick();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h64; d_wdata[0] = 32'd25;
    @(negedge clk);
    chk1("st_gnt", 0, d_gnt[0], 1'b1);
    chk1("st_mem_we", 0, mem_we[0], 1'b1);
    chk32("st_mem_wdata", 0, mem_wdata[0], 32'd25);
    tick();
    d_we[0] = 1'b0; d_wdata[0] = 32'h0;
    @(negedge clk);
    chk1("ld_wait", 0, d_gnt[0], 1'b0);
    tick();
    @(negedge clk);
    chk1("st_rvalid", 0, d_rvalid[0], 1'b1);
    chk32("st_rdata", 0, d_rdata[0], 32'h0);
    chk1("ld_gnt", 0, d_gnt[0], 1'b1);
    chk1("ld_mem_we", 0, mem_we[0], 1'b0);
    tick();
    d_req[0] = 1'b0;
    tick();
    @(negedge clk);
    chk1("ld_rvalid", 0, d_rvalid[0], 1'b1);
    chk32("ld_rdata", 0, d_rdata[0], 32'd25);

    // Starvation guard: both held, expect D D D D IF D D.
    tick();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20;
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    seq = 32'h0;
    ng  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if_gnt[0] || d_gnt[0]) begin
        seq[ng] = if_gnt[0];
        ng++;
      end
      if (ng == 7) break;
      tick();
    end
    chk32("streak_ngrants", 0, 32'(ng), 32'd7);
    chk32("streak_seq", 0, seq, 32'h0000_0010);
    tick();
    d_req[0] = 1'b0; if_req[0] = 1'b0;
    tick(); tick(); tick();

    // Mid-access reset, MEM_LAT = 3.
    tick();
    if_req[1] = 1'b1; if_addr[1] = 32'hC;
    @(negedge clk);
    chk1("mr_gnt", 1, if_gnt[1], 1'b1);
    tick();
    if_req[1] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    chk1("mr_busy", 1, busy[1], 1'b0);
    chk1("mr_mem_en", 1, mem_en[1], 1'b0);
    chk1("mr_rvalid", 1, if_rvalid[1], 1'b0);
    tick();
    rst[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("mr_no_rvalid", 1, if_rvalid[1], 1'b0);
      chk1("mr_idle", 1, busy[1], 1'b0);
      tick();
    end
    if_req[1] = 1'b1; if_addr[1] = 32'h14;
    @(negedge clk);
    chk1("mr_fresh_gnt", 1, if_gnt[1], 1'b1);
    tick();
    if_req[1] = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk1("mr_fresh_rvalid", 1, if_rvalid[1], 1'b1);
    chk32("mr_fresh_rdata", 1, if_rdata[1], 32'hC0DE_0005);

    // MEM_LAT = 1 streaming: eight back-to-back fetches.
    tick();
    for (int i = 0; i < 8; i++) begin
      if_req[2] = 1'b1; if_addr[2] = 32'(i * 4);
      @(negedge clk);
      chk1("stream_gnt", 2, if_gnt[2], 1'b1);
      if (i > 0) begin
        chk1("stream_rvalid", 2, if_rvalid[2], 1'b1);
        chk32("stream_rdata", 2, if_rdata[2], init_word(i - 1));
      end
      tick();
    end
    if_req[2] = 1'b0;
    @(negedge clk);
    chk1("stream_last_rvalid", 2, if_rvalid[2], 1'b1);
    chk32("stream_last_rdata", 2, if_rdata[2], init_word(7));
    chk1("stream_no_gnt", 2, if_gnt[2], 1'b0);
    tick();
    @(negedge clk);
    chk1("stream_done", 2, if_rvalid[2], 1'b0);
    chk1("stream_idle", 2, busy[2], 1'b0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
